// File: rtl/key_conditioner.sv
// Push-button conditioner: per-key synchronizer, debounce FSM, clean level and
// single-cycle press/release pulses for the active-low Run/Continue board keys.
module key_conditioner #(
  parameter int N_KEYS          = 2,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [N_KEYS-1:0]     key_n_in,
  output logic [N_KEYS-1:0]     key_level,
  output logic [N_KEYS-1:0]     key_press,
  output logic [N_KEYS-1:0]     key_release,
  output logic [N_KEYS-1:0]     key_n_out,
  output logic [2*N_KEYS-1:0]   key_state_dbg
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_UP        = 2'd0,
    ST_WAIT_DOWN = 2'd1,
    ST_DOWN      = 2'd2,
    ST_WAIT_UP   = 2'd3
  } state_e;

  logic [N_KEYS-1:0][SYNC_STAGES-1:0] sync_q;
  logic [N_KEYS-1:0]                  key_pressed;

  state_e           state_q   [N_KEYS];
  state_e           state_d   [N_KEYS];
  logic [CNT_W-1:0] cnt_q     [N_KEYS];
  logic [CNT_W-1:0] cnt_d     [N_KEYS];
  logic [N_KEYS-1:0] level_q, level_d;
  logic [N_KEYS-1:0] press_q, press_d;
  logic [N_KEYS-1:0] release_q, release_d;

  // Synchronizers reset to "released" so a key held through reset is seen as a fresh press.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      sync_q <= '1;
    end else begin
      for (int i = 0; i < N_KEYS; i++) begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], key_n_in[i]};
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_KEYS; i++) begin
      key_pressed[i] = ~sync_q[i][SYNC_STAGES-1];
    end
  end

  // State register: FSM state, stability counter and the registered outputs.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < N_KEYS; i++) begin
        state_q[i] <= ST_UP;
        cnt_q[i]   <= '0;
      end
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
    end else begin
      for (int i = 0; i < N_KEYS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  // Next-state logic; a change is accepted only after DEBOUNCE_CYCLES+1 stable samples.
  always_comb begin
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        ST_UP: begin
          if (key_pressed[i]) begin
            state_d[i] = ST_WAIT_DOWN;
            cnt_d[i]   = CNT_ONE;
          end else begin
            cnt_d[i] = '0;
          end
        end
        ST_WAIT_DOWN: begin
          if (!key_pressed[i]) begin
            state_d[i] = ST_UP;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] >= CNT_MAX) begin
            state_d[i] = ST_DOWN;
            cnt_d[i]   = '0;
            level_d[i] = 1'b1;
            press_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        ST_DOWN: begin
          if (!key_pressed[i]) begin
            state_d[i] = ST_WAIT_UP;
            cnt_d[i]   = CNT_ONE;
          end else begin
            cnt_d[i] = '0;
          end
        end
        ST_WAIT_UP: begin
          if (key_pressed[i]) begin
            state_d[i] = ST_DOWN;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] >= CNT_MAX) begin
            state_d[i]   = ST_UP;
            cnt_d[i]     = '0;
            level_d[i]   = 1'b0;
            release_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        default: begin
          state_d[i] = ST_UP;
          cnt_d[i]   = '0;
          level_d[i] = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    key_level   = level_q;
    key_press   = press_q;
    key_release = release_q;
    key_n_out   = ~level_q;
    for (int i = 0; i < N_KEYS; i++) begin
      key_state_dbg[2*i +: 2] = state_q[i];
    end
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: run-length reference model feeds an expected queue,
// a negedge monitor compares every output cycle; directed scenarios check latency.
module tb_key_conditioner;

  localparam int N  = 2;
  localparam int SS = 2;
  localparam int DC = 4;
  localparam int W  = 4 * N;
  localparam int LAT = SS + DC + 1;
  localparam logic [W-1:0] RESET_EXP = {{N{1'b0}}, {N{1'b0}}, {N{1'b0}}, {N{1'b1}}};

  logic          Clk = 1'b0;
  logic          Reset;
  logic [N-1:0]  key_n_in;
  logic [N-1:0]  key_level, key_press, key_release, key_n_out;
  logic [2*N-1:0] key_state_dbg;

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_exp;

  key_conditioner #(.N_KEYS(N), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC)) dut (
    .Clk(Clk), .Reset(Reset), .key_n_in(key_n_in),
    .key_level(key_level), .key_press(key_press), .key_release(key_release),
    .key_n_out(key_n_out), .key_state_dbg(key_state_dbg)
  );

  // clock / reset
  always #5 Clk = ~Clk;

  function automatic void check_vec(string name, logic [W-1:0] got, logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got=%b exp=%b (level,press,release,n_out)", name, $time, got, exp);
    end
  endfunction

  function automatic void check_int(string name, int got, int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got=%0d exp=%0d", name, $time, got, exp);
    end
  endfunction

  // Reference model: a key's accepted level flips once DC+1 consecutive synced
  // samples disagree with it; synced sample = raw value delayed by SS edges.
  logic [N-1:0] raw_q[$];
  logic [N-1:0] m_level, m_s, m_pr, m_rl;
  int           run [N];

  always @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      exp_q.delete();
      raw_q.delete();
      for (int k = 0; k < SS; k++) raw_q.push_back('1);
      m_level = '0;
      for (int i = 0; i < N; i++) run[i] = 0;
    end else begin
      raw_q.push_back(key_n_in);
      m_s  = ~raw_q.pop_front();
      m_pr = '0;
      m_rl = '0;
      for (int i = 0; i < N; i++) begin
        if (m_s[i] != m_level[i]) run[i]++;
        else run[i] = 0;
        if (run[i] == DC + 1) begin
          m_level[i] = ~m_level[i];
          run[i] = 0;
          if (m_level[i]) m_pr[i] = 1'b1;
          else m_rl[i] = 1'b1;
        end
      end
      exp_q.push_back({m_level, m_pr, m_rl, ~m_level});
    end
  end

  // monitor
  always @(negedge Clk) begin
    if (!Reset) begin
      last_exp = RESET_EXP;
      check_vec("reset_outputs", {key_level, key_press, key_release, key_n_out}, RESET_EXP);
    end else begin
      if (exp_q.size() > 0) last_exp = exp_q.pop_front();
      check_vec("cycle_outputs", {key_level, key_press, key_release, key_n_out}, last_exp);
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic measure_edge(input int k, input logic target, input string name);
    int found;
    found = 0;
    for (int e = 1; e <= 30 && found == 0; e++) begin
      @(posedge Clk);
      #1;
      if (key_level[k] === target) found = e;
    end
    check_int(name, found, LAT);
  endtask

  initial begin
    int  found;
    bool_stable: begin end
    Reset    = 1'b0;
    key_n_in = '1;
    repeat (3) @(posedge Clk);
    #1;
    Reset = 1'b1;
    tick(5);

    // single press on key 0
    key_n_in[0] = 1'b0;
    measure_edge(0, 1'b1, "press0_latency");
    tick(13);

    // bouncing key 1, then settle
    repeat (5) begin
      key_n_in[1] = 1'b0; tick(3);
      key_n_in[1] = 1'b1; tick(2);
    end
    key_n_in[1] = 1'b0;
    measure_edge(1, 1'b1, "press1_after_bounce");
    tick(5);

    // release key 0, re-press, then a short glitch that must not release it
    key_n_in[0] = 1'b1;
    measure_edge(0, 1'b0, "release0_latency");
    key_n_in[0] = 1'b0;
    tick(12);
    key_n_in[0] = 1'b1; tick(2);
    key_n_in[0] = 1'b0;
    found = 1;
    repeat (15) begin
      tick(1);
      if (key_level[0] !== 1'b1) found = 0;
    end
    check_int("glitch_no_release", found, 1);

    // release both, then press both on the same edge
    key_n_in = '1;
    tick(15);
    key_n_in = '0;
    found = 0;
    for (int e = 1; e <= 30 && found == 0; e++) begin
      tick(1);
      if (key_level != '0) begin
        found = e;
        check_vec("both_press_pulse", {key_level, key_press, key_release, key_n_out},
                  {2'b11, 2'b11, 2'b00, 2'b00});
      end
    end
    check_int("both_press_latency", found, LAT);
    tick(3);

    // reset mid-debounce: key 1 held down, key 0 freshly pressed
    key_n_in = 2'b01;
    tick(15);
    key_n_in[0] = 1'b0;
    tick(4);
    Reset = 1'b0;
    #1;
    check_vec("async_reset_clear", {key_level, key_press, key_release, key_n_out}, RESET_EXP);
    tick(2);
    Reset = 1'b1;
    measure_edge(0, 1'b1, "press_after_reset");
    tick(10);

    // randomized keys with occasional resets
    for (int it = 0; it < 300; it++) begin
      key_n_in = N'($urandom_range(0, (1 << N) - 1));
      if ($urandom_range(0, 49) == 0) begin
        Reset = 1'b0;
        tick($urandom_range(1, 2));
        Reset = 1'b1;
      end
      tick($urandom_range(1, 9));
    end
    key_n_in = '1;
    tick(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
